// File: rtl/bdc_drive_sequencer_pkg.sv
// Shared encodings for the brushed-DC H-bridge drive sequencer:
// FSM states, gate bit positions, static drive patterns and directions.
package bdc_drive_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DECEL = 3'd2,
        ST_DEAD  = 3'd3,
        ST_BRAKE = 3'd4
    } drv_state_t;

    localparam int GATE_AH = 0;
    localparam int GATE_AL = 1;
    localparam int GATE_BH = 2;
    localparam int GATE_BL = 3;

    // FWD/REV hold only the static low-side gate; the PWM high side is merged in.
    localparam logic [3:0] PAT_OFF   = 4'b0000;
    localparam logic [3:0] PAT_FWD   = 4'b1000;
    localparam logic [3:0] PAT_REV   = 4'b0010;
    localparam logic [3:0] PAT_BRAKE = 4'b1010;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    function automatic logic [3:0] drive_pattern(input drv_state_t st,
                                                 input logic       dir,
                                                 input logic       pwm_on);
        logic [3:0] pat;
        pat = PAT_OFF;
        case (st)
            ST_RUN, ST_DECEL: begin
                if (dir == DIR_FWD) begin
                    pat          = PAT_FWD;
                    pat[GATE_AH] = pwm_on;
                end else begin
                    pat          = PAT_REV;
                    pat[GATE_BH] = pwm_on;
                end
            end
            ST_BRAKE: pat = PAT_BRAKE;
            default:  pat = PAT_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bdc_drive_sequencer_pwm_gen.sv
// Free-running PWM period counter with a duty shadow register that only
// reloads at counter wrap, so a running period is never truncated.
module bdc_pwm_gen
    import bdc_drive_sequencer_pkg::*;
#(
    parameter int PWM_BITS = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] duty,
    output logic       pwm_on
);

    logic [PWM_BITS-1:0] cnt_q;
    logic [7:0]          shadow_q;
    logic                wrap;

    assign wrap = &cnt_q;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q <= cnt_q + PWM_BITS'(1);
            if (wrap) shadow_q <= duty;
        end
    end

    // Compare the 8-bit duty against the counter at matching resolution.
    generate
        if (PWM_BITS > 8) begin : g_wide
            logic unused_lsbs;
            assign unused_lsbs = ^cnt_q[PWM_BITS-9:0];
            assign pwm_on      = cnt_q[PWM_BITS-1 -: 8] < shadow_q;
        end else if (PWM_BITS == 8) begin : g_exact
            assign pwm_on = cnt_q < shadow_q;
        end else begin : g_narrow
            logic unused_lsbs;
            assign unused_lsbs = ^shadow_q[7-PWM_BITS:0];
            assign pwm_on      = cnt_q < shadow_q[7 -: PWM_BITS];
        end
    endgenerate

endmodule

// File: rtl/bdc_drive_sequencer.sv
// H-bridge gate sequencer: ramps duty toward the commanded target, inserts
// dead time on every gate-pair handover and brakes when the host goes silent.
module bdc_drive_sequencer
    import bdc_drive_sequencer_pkg::*;
#(
    parameter int PWM_BITS    = 11,
    parameter int RAMP_DIV    = 4096,
    parameter int DEAD_CYCLES = 49,
    parameter int WDOG_CYCLES = 49152000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_dir,
    input  logic [7:0] cmd_duty,
    input  logic       cmd_brake,
    output logic [3:0] motor_pwm,
    output logic [7:0] cur_duty,
    output logic [2:0] drv_state,
    output logic       wdog_fault
);

    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    drv_state_t        state_q, state_d;
    logic              to_brake_q, to_brake_d;
    logic              dir_cur_q, dir_cur_d;
    logic              dir_pend_q, dir_pend_d;
    logic [7:0]        target_q, target_d;
    logic [7:0]        tgt_pend_q, tgt_pend_d;
    logic [7:0]        cur_q, cur_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              fault_q, fault_d;
    logic [RAMP_W-1:0] ramp_cnt_q;

    logic ramp_tick, pwm_on, cmd_run, wdog_counting, wdog_trip, brake_req;

    bdc_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .duty   (cur_q),
        .pwm_on (pwm_on)
    );

    assign ramp_tick     = (ramp_cnt_q == RAMP_LAST);
    assign cmd_run       = cmd_valid && !cmd_brake;
    assign wdog_counting = (state_q == ST_RUN) || (state_q == ST_DECEL);
    // A command landing on the expiry cycle suppresses the trip.
    assign wdog_trip     = wdog_counting && !cmd_valid && (wdog_cnt_q == WDOG_LAST);
    assign brake_req     = (cmd_valid && cmd_brake) || wdog_trip;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        to_brake_d = to_brake_q;
        dir_cur_d  = dir_cur_q;
        dir_pend_d = dir_pend_q;
        target_d   = target_q;
        tgt_pend_d = tgt_pend_q;
        cur_d      = cur_q;
        dead_cnt_d = dead_cnt_q;
        wdog_cnt_d = wdog_cnt_q;
        fault_d    = fault_q;

        if (cmd_valid) begin
            wdog_cnt_d = '0;
            fault_d    = 1'b0;
        end else if (wdog_trip) begin
            wdog_cnt_d = '0;
            fault_d    = 1'b1;
        end else if (wdog_counting) begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
        end

        if (brake_req && (state_q != ST_DEAD) && (state_q != ST_BRAKE)) begin
            // Low sides only close after a full dead time with every gate off.
            state_d    = ST_DEAD;
            to_brake_d = 1'b1;
            cur_d      = 8'd0;
            target_d   = 8'd0;
            dead_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_run && (cmd_duty != 8'd0)) begin
                        state_d   = ST_RUN;
                        dir_cur_d = cmd_dir;
                        target_d  = cmd_duty;
                    end
                end
                ST_RUN: begin
                    if (cmd_run) begin
                        if (cmd_dir == dir_cur_q) begin
                            target_d = cmd_duty;
                        end else begin
                            dir_pend_d = cmd_dir;
                            tgt_pend_d = cmd_duty;
                            target_d   = 8'd0;
                            state_d    = ST_DECEL;
                        end
                    end else if ((cur_q == 8'd0) && (target_q == 8'd0)) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DECEL: begin
                    if (cmd_run) begin
                        dir_pend_d = cmd_dir;
                        tgt_pend_d = cmd_duty;
                    end
                    if (cur_q == 8'd0) begin
                        state_d    = ST_DEAD;
                        to_brake_d = 1'b0;
                        dead_cnt_d = '0;
                    end
                end
                ST_DEAD: begin
                    if (cmd_valid && cmd_brake) begin
                        to_brake_d = 1'b1;
                    end else if (cmd_run) begin
                        dir_pend_d = cmd_dir;
                        tgt_pend_d = cmd_duty;
                        if (cmd_duty != 8'd0) to_brake_d = 1'b0;
                    end
                    if (dead_cnt_q == DEAD_LAST) begin
                        if (to_brake_d) begin
                            state_d = ST_BRAKE;
                        end else begin
                            dir_cur_d = dir_pend_d;
                            target_d  = tgt_pend_d;
                            state_d   = (tgt_pend_d == 8'd0) ? ST_IDLE : ST_RUN;
                        end
                    end else begin
                        dead_cnt_d = dead_cnt_q + DEAD_W'(1);
                    end
                end
                ST_BRAKE: begin
                    if (cmd_run && (cmd_duty != 8'd0)) begin
                        dir_pend_d = cmd_dir;
                        tgt_pend_d = cmd_duty;
                        to_brake_d = 1'b0;
                        dead_cnt_d = '0;
                        state_d    = ST_DEAD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A ramp tick coinciding with a state change is dropped.
            if (ramp_tick && (state_d == state_q) &&
                ((state_q == ST_RUN) || (state_q == ST_DECEL))) begin
                if (cur_q < target_d)      cur_d = cur_q + 8'd1;
                else if (cur_q > target_d) cur_d = cur_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            to_brake_q <= 1'b0;
            dir_cur_q  <= DIR_FWD;
            dir_pend_q <= DIR_FWD;
            target_q   <= 8'd0;
            tgt_pend_q <= 8'd0;
            cur_q      <= 8'd0;
            dead_cnt_q <= '0;
            wdog_cnt_q <= '0;
            fault_q    <= 1'b0;
            ramp_cnt_q <= '0;
            motor_pwm  <= PAT_OFF;
        end else begin
            state_q    <= state_d;
            to_brake_q <= to_brake_d;
            dir_cur_q  <= dir_cur_d;
            dir_pend_q <= dir_pend_d;
            target_q   <= target_d;
            tgt_pend_q <= tgt_pend_d;
            cur_q      <= cur_d;
            dead_cnt_q <= dead_cnt_d;
            wdog_cnt_q <= wdog_cnt_d;
            fault_q    <= fault_d;
            ramp_cnt_q <= ramp_tick ? '0 : ramp_cnt_q + RAMP_W'(1);
            motor_pwm  <= drive_pattern(state_q, dir_cur_q, pwm_on);
        end
    end

    assign cur_duty   = cur_q;
    assign drv_state  = state_q;
    assign wdog_fault = fault_q;

endmodule

// File: tb/tb_bdc_drive_sequencer.sv
// Self-checking bench: directed scenarios plus random command traffic, all
// compared every cycle against a behavioural model of the drive rules.
module tb_bdc_drive_sequencer;

    localparam int PWM_BITS    = 6;
    localparam int RAMP_DIV    = 4;
    localparam int DEAD_CYCLES = 8;
    localparam int WDOG_CYCLES = 2000;
    localparam int PERIOD      = 1 << PWM_BITS;

    localparam int M_IDLE = 0, M_RUN = 1, M_DECEL = 2, M_DEAD = 3, M_BRAKE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_dir = 1'b0;
    logic [7:0] cmd_duty = 8'd0;
    logic       cmd_brake = 1'b0;
    logic [3:0] motor_pwm;
    logic [7:0] cur_duty;
    logic [2:0] drv_state;
    logic       wdog_fault;

    always #5 clk = ~clk;

    bdc_drive_sequencer #(
        .PWM_BITS(PWM_BITS), .RAMP_DIV(RAMP_DIV),
        .DEAD_CYCLES(DEAD_CYCLES), .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
        .cmd_duty(cmd_duty), .cmd_brake(cmd_brake), .motor_pwm(motor_pwm),
        .cur_duty(cur_duty), .drv_state(drv_state), .wdog_fault(wdog_fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: values the DUT outputs should hold after the last edge.
    int         m_mode, m_tgt, m_ptgt, m_cur, m_left, m_silence, m_pos, m_shadow, m_rphase;
    bit         m_dir, m_pdir, m_to_brake, m_fault;
    logic [3:0] m_gates;

    task automatic model_reset();
        m_mode = M_IDLE; m_tgt = 0; m_ptgt = 0; m_cur = 0; m_left = 0;
        m_silence = 0; m_pos = 0; m_shadow = 0; m_rphase = 0;
        m_dir = 0; m_pdir = 0; m_to_brake = 0; m_fault = 0; m_gates = 4'b0000;
    endtask

    task automatic model_step(input bit v, input bit d, input int duty, input bit b);
        bit on, tick, counting, trip;
        int old_mode;
        logic [3:0] g;
        on = m_pos < (m_shadow * PERIOD) / 256;
        g = 4'b0000;
        if (m_mode == M_RUN || m_mode == M_DECEL) begin
            if (!m_dir) begin g[0] = on; g[3] = 1'b1; end
            else        begin g[2] = on; g[1] = 1'b1; end
        end else if (m_mode == M_BRAKE) begin
            g = 4'b1010;
        end
        if (m_pos == PERIOD - 1) m_shadow = m_cur;
        m_pos    = (m_pos + 1) % PERIOD;
        tick     = (m_rphase == RAMP_DIV - 1);
        m_rphase = (m_rphase + 1) % RAMP_DIV;

        counting = (m_mode == M_RUN || m_mode == M_DECEL);
        trip     = counting && !v && (m_silence == WDOG_CYCLES - 1);
        if (v)             begin m_silence = 0; m_fault = 0; end
        else if (trip)     begin m_silence = 0; m_fault = 1; end
        else if (counting) m_silence++;

        old_mode = m_mode;
        if (((v && b) || trip) && m_mode != M_DEAD && m_mode != M_BRAKE) begin
            m_mode = M_DEAD; m_left = DEAD_CYCLES; m_to_brake = 1; m_cur = 0; m_tgt = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (v && duty > 0) begin m_mode = M_RUN; m_dir = d; m_tgt = duty; end
                M_RUN: begin
                    if (v) begin
                        if (d == m_dir) m_tgt = duty;
                        else begin m_pdir = d; m_ptgt = duty; m_tgt = 0; m_mode = M_DECEL; end
                    end else if (m_cur == 0 && m_tgt == 0) m_mode = M_IDLE;
                end
                M_DECEL: begin
                    if (v) begin m_pdir = d; m_ptgt = duty; end
                    if (m_cur == 0) begin m_mode = M_DEAD; m_left = DEAD_CYCLES; m_to_brake = 0; end
                end
                M_DEAD: begin
                    if (v && b) m_to_brake = 1;
                    else if (v) begin
                        m_pdir = d; m_ptgt = duty;
                        if (duty > 0) m_to_brake = 0;
                    end
                    m_left--;
                    if (m_left == 0) begin
                        if (m_to_brake) m_mode = M_BRAKE;
                        else begin
                            m_dir = m_pdir; m_tgt = m_ptgt;
                            m_mode = (m_ptgt == 0) ? M_IDLE : M_RUN;
                        end
                    end
                end
                M_BRAKE: if (v && !b && duty > 0) begin
                    m_pdir = d; m_ptgt = duty; m_to_brake = 0;
                    m_left = DEAD_CYCLES; m_mode = M_DEAD;
                end
                default: m_mode = M_IDLE;
            endcase
            if (tick && m_mode == old_mode && (m_mode == M_RUN || m_mode == M_DECEL)) begin
                if (m_cur < m_tgt)      m_cur++;
                else if (m_cur > m_tgt) m_cur--;
            end
        end
        m_gates = g;
    endtask

    int ah_high, zrun, max_zrun, bl_low, al_bh_high;

    task automatic cycle(input bit v, input bit d, input int duty, input bit b);
        @(negedge clk);
        check("gates", 32'(motor_pwm), 32'(m_gates));
        check("cur_duty", 32'(cur_duty), 32'(m_cur));
        check("drv_state", 32'(drv_state), 32'(m_mode));
        check("wdog_fault", 32'(wdog_fault), 32'(m_fault));
        check("shoot_through", 32'((motor_pwm[0] & motor_pwm[1]) | (motor_pwm[2] & motor_pwm[3])), 32'd0);
        if (motor_pwm == 4'b0000) begin
            zrun++;
            if (zrun > max_zrun) max_zrun = zrun;
        end else zrun = 0;
        if (motor_pwm[0])                 ah_high++;
        if (!motor_pwm[3])                bl_low++;
        if (motor_pwm[1] || motor_pwm[2]) al_bh_high++;
        cmd_valid = v; cmd_dir = d; cmd_duty = 8'(duty); cmd_brake = b;
        model_step(v, d, duty, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic clear_meas();
        ah_high = 0; zrun = 0; max_zrun = 0; bl_low = 0; al_bh_high = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        cmd_valid = 0; cmd_dir = 0; cmd_duty = 0; cmd_brake = 0;
        model_reset();
        model_step(0, 0, 0, 0);
    endtask

    task automatic random_phase(input int n, input int rate_per_10k);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9999) < rate_per_10k) begin
                cycle(1, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255)),
                      $urandom_range(0, 9) < 2);
            end else cycle(0, 0, 0, 0);
        end
    endtask

    initial begin
        int k;
        clear_meas();
        model_reset();

        // Reset state
        #2 reset = 1'b1;
        #6;
        check("rst_gates", 32'(motor_pwm), 32'd0);
        check("rst_duty", 32'(cur_duty), 32'd0);
        check("rst_state", 32'(drv_state), 32'd0);
        check("rst_fault", 32'(wdog_fault), 32'd0);
        release_reset();

        // Forward ramp to 128: half-period high side, BL held on
        cycle(1, 0, 128, 0);
        idle(600);
        check("fwd128_duty", 32'(cur_duty), 32'd128);
        clear_meas();
        idle(PERIOD);
        check("fwd128_ah_width", 32'(ah_high), 32'd32);
        check("fwd128_bl_low", 32'(bl_low), 32'd0);
        check("fwd128_al_bh", 32'(al_bh_high), 32'd0);

        // Full-scale and zero duty
        cycle(1, 0, 255, 0);
        idle(600);
        clear_meas();
        idle(PERIOD);
        check("fwd255_ah_width", 32'(ah_high), 32'(PERIOD - 1));
        cycle(1, 0, 0, 0);
        idle(1100);
        check("zero_idle_state", 32'(drv_state), 32'd0);
        clear_meas();
        idle(PERIOD);
        check("zero_ah_width", 32'(ah_high), 32'd0);

        // Direction reversal: decel, exactly DEAD_CYCLES of all-off, then REV
        cycle(1, 0, 100, 0);
        idle(450);
        clear_meas();
        cycle(1, 1, 50, 0);
        idle(700);
        check("rev_dead_len", 32'(max_zrun), 32'(DEAD_CYCLES));
        check("rev_duty", 32'(cur_duty), 32'd50);
        check("rev_al_on", 32'(motor_pwm[1]), 32'd1);

        // Brake from RUN and recovery
        cycle(1, 1, 200, 0);
        idle(700);
        clear_meas();
        cycle(1, 0, 0, 1);
        idle(1);
        check("brake_duty0", 32'(cur_duty), 32'd0);
        idle(100);
        check("brake_dead_len", 32'(max_zrun), 32'(DEAD_CYCLES));
        check("brake_pattern", 32'(motor_pwm), 32'b1010);
        clear_meas();
        cycle(1, 0, 10, 0);
        idle(100);
        check("unbrake_dead_len", 32'(max_zrun), 32'(DEAD_CYCLES));
        check("unbrake_state", 32'(drv_state), 32'd1);
        check("unbrake_bl", 32'(motor_pwm[3]), 32'd1);

        // Watchdog trip after silence, cleared by next command
        idle(WDOG_CYCLES + 50);
        check("wdog_trip_fault", 32'(wdog_fault), 32'd1);
        check("wdog_trip_state", 32'(drv_state), 32'd4);
        check("wdog_trip_gates", 32'(motor_pwm), 32'b1010);
        cycle(1, 0, 60, 0);
        idle(20);
        check("wdog_clear", 32'(wdog_fault), 32'd0);

        // Command landing exactly on the expiry cycle prevents the trip
        k = 0;
        while (m_silence != WDOG_CYCLES - 1 && k < WDOG_CYCLES + 100) begin
            cycle(0, 0, 0, 0);
            k++;
        end
        check("expiry_reached", 32'(m_silence), 32'(WDOG_CYCLES - 1));
        cycle(1, 0, 60, 0);
        idle(20);
        check("expiry_no_trip", 32'(wdog_fault), 32'd0);
        check("expiry_state", 32'(drv_state), 32'd1);

        // Random command traffic, then sparse traffic that lets the watchdog fire
        random_phase(8000, 70);
        random_phase(6000, 4);

        // Asynchronous reset while the high side is on
        cycle(1, 0, 128, 0);
        k = 0;
        while (!(motor_pwm[0] === 1'b1 && m_mode == M_RUN) && k < 1500) begin
            cycle(0, 0, 0, 0);
            k++;
        end
        check("ah_reached", 32'(motor_pwm[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_gates", 32'(motor_pwm), 32'd0);
        check("async_rst_state", 32'(drv_state), 32'd0);
        release_reset();
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
